hex_debug_display: RTL and testbench

Downstream consumer of the debug selector on the DE10-Lite board. Registers the selector's 16-bit `selected` word and drives it as four hex digits on HEX3..HEX0. HEX4 shows the 3-bit switch code and HEX5 shows a freeze indicator. Flashes the decimal points after every value change, and supports a debounced push-button freeze so a transient value can be read by eye.

---
 rtl/hexdisp_pkg.sv | 37 +++
 rtl/key_debounce.sv | 46 ++++
 rtl/hex_debug_display.sv | 129 ++++++++++++
 tb/tb_hex_debug_display.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/hexdisp_pkg.sv
// Shared definitions for the hex debug display: seven-segment font,
// segment constants and the change-flash state type.
package hexdisp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_F     = 7'h0E;

  typedef enum logic {
    IDLE  = 1'b0,
    FLASH = 1'b1
  } chg_state_t;

  // Active-low segments, bit order g..a.
  function automatic logic [6:0] hex2seg(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchroniser plus stable-time debouncer.
// level is the accepted key level (active-low key); press pulses for one cycle on each accepted 1->0.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      // Any agreement with the accepted level restarts the stability window.
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
          press <= ~sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/hex_debug_display.sv
// Shows the debug selector word on HEX3..HEX0, the switch code on HEX4 and a freeze flag on HEX5,
// flashing the DPs after each change. Build option HEXDISP_FREEZE_EN enables the KEY freeze.
module hex_debug_display
  import hexdisp_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_CYCLES    = 12500000,
  parameter int CHANGE_BLINKS   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic [2:0]  sel,
  input  logic        freeze_n,
  output logic [7:0]  HEX0,
  output logic [7:0]  HEX1,
  output logic [7:0]  HEX2,
  output logic [7:0]  HEX3,
  output logic [7:0]  HEX4,
  output logic [7:0]  HEX5,
  output logic        frozen
);

  localparam int HW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int TW = $clog2(2 * CHANGE_BLINKS + 1);
  localparam logic [HW-1:0] HALF_RELOAD = HW'(BLINK_CYCLES - 1);
  localparam logic [TW-1:0] TOG_RELOAD  = TW'(2 * CHANGE_BLINKS);

  logic [15:0]   disp_q;
  chg_state_t    state;
  logic [HW-1:0] half_cnt;
  logic [TW-1:0] toggles_left;
  logic          dp_on;
  logic          change;

`ifdef HEXDISP_FREEZE_EN
  logic key_press;
  logic key_level_unused;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (freeze_n),
    .level (key_level_unused),
    .press (key_press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frozen <= 1'b0;
      HEX5   <= {1'b1, SEG_BLANK};
    end else begin
      if (key_press) begin
        frozen <= ~frozen;
      end
      HEX5 <= {1'b1, frozen ? SEG_F : SEG_BLANK};
    end
  end
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
  logic unused_freeze_n;

  assign unused_freeze_n = freeze_n;
  assign frozen          = 1'b0;
  assign HEX5            = 8'hFF;
`endif

  // While frozen the held word is stale by design, so it must not count as a change.
  assign change = !frozen && (value != disp_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q <= '0;
    end else if (!frozen) begin
      disp_q <= value;
    end
  end

  // state | meaning
  // IDLE  | display steady, DPs dark
  // FLASH | DPs blinking after a change; toggles_left half-periods remain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      half_cnt     <= '0;
      toggles_left <= '0;
      dp_on        <= 1'b0;
    end else begin
      if (change) begin
        state        <= FLASH;
        half_cnt     <= HALF_RELOAD;
        toggles_left <= TOG_RELOAD;
        dp_on        <= 1'b1;
      end else if (state == FLASH) begin
        if (half_cnt == '0) begin
          half_cnt     <= HALF_RELOAD;
          toggles_left <= toggles_left - 1'b1;
          if (toggles_left == TW'(1)) begin
            state <= IDLE;
            dp_on <= 1'b0;
          end else begin
            dp_on <= ~dp_on;
          end
        end else begin
          half_cnt <= half_cnt - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      HEX0 <= 8'hC0;
      HEX1 <= 8'hC0;
      HEX2 <= 8'hC0;
      HEX3 <= 8'hC0;
      HEX4 <= 8'hC0;
    end else begin
      HEX0 <= {~dp_on, hex2seg(disp_q[3:0])};
      HEX1 <= {~dp_on, hex2seg(disp_q[7:4])};
      HEX2 <= {~dp_on, hex2seg(disp_q[11:8])};
      HEX3 <= {~dp_on, hex2seg(disp_q[15:12])};
      HEX4 <= {1'b1, hex2seg({1'b0, sel})};
    end
  end

endmodule

// File: tb/tb_hex_debug_display.sv
// Self-checking bench for hex_debug_display: timeline reference model plus directed literal checks.
module tb_hex_debug_display;

  localparam int D = 4;
  localparam int B = 3;
  localparam int C = 2;
`ifdef HEXDISP_FREEZE_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  localparam logic [6:0] FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] value = 16'h0000;
  logic [2:0]  sel = 3'd0;
  logic        freeze_n = 1'b1;
  logic [7:0]  h0, h1, h2, h3, h4, h5;
  logic        frozen;

  int n_checks = 0;
  int n_fail   = 0;

  hex_debug_display #(
    .DEBOUNCE_CYCLES(D),
    .BLINK_CYCLES   (B),
    .CHANGE_BLINKS  (C)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .value    (value),
    .sel      (sel),
    .freeze_n (freeze_n),
    .HEX0     (h0),
    .HEX1     (h1),
    .HEX2     (h2),
    .HEX3     (h3),
    .HEX4     (h4),
    .HEX5     (h5),
    .frozen   (frozen)
  );

  always #5 clk = ~clk;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: display word, freeze flag, and time elapsed in the current flash.
  logic [15:0] m_disp = '0;
  bit          m_frozen = 0;
  bit          m_flash = 0;
  int          m_t = 0;
  bit          m_s1 = 1, m_s2 = 1, m_level = 1, m_pend = 0;
  int          m_run = 0;
  logic [7:0]  exp_hex [6] = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hFF};
  bit          dp_old, chg, nf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_disp = '0; m_frozen = 0; m_flash = 0; m_t = 0;
      m_s1 = 1; m_s2 = 1; m_level = 1; m_pend = 0; m_run = 0;
      for (int i = 0; i < 5; i++) exp_hex[i] = 8'hC0;
      exp_hex[5] = 8'hFF;
    end else begin
      dp_old = m_flash && (((m_t / B) % 2) == 0);
      for (int i = 0; i < 4; i++) exp_hex[i] = {~dp_old, FONT[m_disp[4*i +: 4]]};
      exp_hex[4] = {1'b1, FONT[{1'b0, sel}]};
      exp_hex[5] = (FE && m_frozen) ? 8'h8E : 8'hFF;
      chg = !m_frozen && (value != m_disp);
      if (!m_frozen) m_disp = value;
      if (chg) begin
        m_flash = 1; m_t = 0;
      end else if (m_flash) begin
        m_t++;
        if (m_t == 2 * C * B) m_flash = 0;
      end
      if (FE) begin
        nf = m_frozen ^ m_pend;
        m_pend = 0;
        if (m_s2 != m_level) begin
          m_run++;
          if (m_run == D) begin
            m_level = m_s2; m_run = 0; m_pend = !m_s2;
          end
        end else begin
          m_run = 0;
        end
        m_s2 = m_s1;
        m_s1 = freeze_n;
        m_frozen = nf;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check8("hex0", h0, exp_hex[0]);
      check8("hex1", h1, exp_hex[1]);
      check8("hex2", h2, exp_hex[2]);
      check8("hex3", h3, exp_hex[3]);
      check8("hex4", h4, exp_hex[4]);
      check8("hex5", h5, exp_hex[5]);
      check8("frozen", {7'd0, frozen}, {7'd0, m_frozen});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic reset_literals(input string tag);
    #1;
    check8({tag, "_hex0"}, h0, 8'hC0);
    check8({tag, "_hex1"}, h1, 8'hC0);
    check8({tag, "_hex2"}, h2, 8'hC0);
    check8({tag, "_hex3"}, h3, 8'hC0);
    check8({tag, "_hex4"}, h4, 8'hC0);
    check8({tag, "_hex5"}, h5, 8'hFF);
    check8({tag, "_frozen"}, {7'd0, frozen}, 8'h00);
  endtask

  task automatic count_dp(input int n, output int lit, output int trans);
    logic prev;
    prev = h0[7];
    lit = 0;
    trans = 0;
    repeat (n) begin
      tick(1);
      if (!h0[7]) lit++;
      if (h0[7] != prev) trans++;
      prev = h0[7];
    end
  endtask

  int lit, trans, fz_hold;

  initial begin
    #1 rst_n = 1'b0;
    reset_literals("rst0");
    tick(2);
    rst_n = 1'b1;
    tick(3);

    value = 16'h1234;
    sel   = 3'd2;
    tick(2);
    #1;
    check8("disp_d3", {1'b0, h3[6:0]}, 8'h79);
    check8("disp_d2", {1'b0, h2[6:0]}, 8'h24);
    check8("disp_d1", {1'b0, h1[6:0]}, 8'h30);
    check8("disp_d0", {1'b0, h0[6:0]}, 8'h19);
    check8("disp_sel", h4, 8'hA4);

    value = 16'hA5F0;
    tick(20);
    value = 16'h0001;
    count_dp(20, lit, trans);
    check8("flash_lit", 8'(lit), 8'd6);
    check8("flash_toggles", 8'(trans), 8'd4);

    value = 16'h1111;
    tick(4);
    value = 16'h2222;
    count_dp(20, lit, trans);
    check8("restart_lit", 8'(lit), 8'd6);

    freeze_n = 1'b0;
    tick(3);
    freeze_n = 1'b1;
    tick(10);
    check8("glitch_frozen", {7'd0, frozen}, 8'h00);

    freeze_n = 1'b0;
    tick(6);
    check8("press_early", {7'd0, frozen}, 8'h00);
    tick(1);
    check8("press_frozen", {7'd0, frozen}, FE ? 8'h01 : 8'h00);
    tick(1);
    check8("press_hex5", h5, FE ? 8'h8E : 8'hFF);
    freeze_n = 1'b1;
    tick(10);
    value = 16'hBEEF;
    tick(5);
    check8("held_d0", {1'b0, h0[6:0]}, FE ? 8'h24 : 8'h0E);

    freeze_n = 1'b0;
    tick(8);
    freeze_n = 1'b1;
    tick(3);
    check8("unfreeze_frozen", {7'd0, frozen}, 8'h00);
    check8("unfreeze_d0", {1'b0, h0[6:0]}, 8'h0E);
    tick(20);

    fz_hold = 0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) value = 16'($urandom);
      sel = 3'($urandom_range(0, 7));
      if (fz_hold == 0) begin
        freeze_n = 1'($urandom_range(0, 1));
        fz_hold  = $urandom_range(1, 12);
      end
      fz_hold--;
      tick(1);
    end

    freeze_n = 1'b1;
    tick(12);
    value = ~value;
    tick(2);
    rst_n = 1'b0;
    reset_literals("rst_mid");
    tick(1);
    rst_n = 1'b1;
    value = 16'hC3D4;
    tick(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
